// File: rtl/conv_ctrl.sv
// Sequencing controller for a 1-D convolution datapath: loads an N-word frame
// into x memory, then walks the M-tap window for each of the N-M+1 outputs.
module conv_ctrl #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int AW = $clog2(N),
    parameter int FW = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic          y_ready,
    output logic          y_valid,
    output logic          wr_en_x,
    output logic [AW-1:0] wr_addr_x,
    output logic [AW-1:0] rd_addr_x,
    output logic [FW-1:0] rd_addr_f,
    output logic          mac_en,
    output logic          mac_first,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [AW-1:0] W_LAST = AW'(N - 1);
    localparam logic [AW-1:0] O_LAST = AW'(N - M);
    localparam logic [FW-1:0] K_LAST = FW'(M - 1);

    state_t        r_state;
    logic [AW-1:0] r_wcnt;
    logic [AW-1:0] r_oidx;
    logic [FW-1:0] r_k;
    logic          r_x_ready;
    logic          r_y_valid;
    logic [AW-1:0] r_rd_addr_x;
    logic [FW-1:0] r_rd_addr_f;
    logic          r_mac_en;
    logic          r_mac_first;
    logic          r_frame_done;

    state_t        w_state_nxt;
    logic [AW-1:0] w_wcnt_nxt;
    logic [AW-1:0] w_oidx_nxt;
    logic [FW-1:0] w_k_nxt;
    logic          w_x_ready_nxt;
    logic          w_y_valid_nxt;
    logic [AW-1:0] w_rd_addr_x_nxt;
    logic [FW-1:0] w_rd_addr_f_nxt;
    logic          w_mac_en_nxt;
    logic          w_mac_first_nxt;
    logic          w_frame_done_nxt;

    logic          w_x_hs;
    logic          w_y_hs;
    logic [AW:0]   w_next_tap_sum;

    assign w_x_hs = x_valid & r_x_ready;
    assign w_y_hs = y_ready & r_y_valid;

    // oidx+k+1 is computed one bit wider; it stays below N because the last tap never advances
    assign w_next_tap_sum = {1'b0, r_oidx} + {{(AW + 1 - FW){1'b0}}, r_k} + {{AW{1'b0}}, 1'b1};

    // Next-state and next-output logic for the load / issue / drain / out sequence
    always_comb begin
        w_state_nxt      = r_state;
        w_wcnt_nxt       = r_wcnt;
        w_oidx_nxt       = r_oidx;
        w_k_nxt          = r_k;
        w_x_ready_nxt    = r_x_ready;
        w_y_valid_nxt    = r_y_valid;
        w_rd_addr_x_nxt  = r_rd_addr_x;
        w_rd_addr_f_nxt  = r_rd_addr_f;
        w_mac_en_nxt     = 1'b0;
        w_mac_first_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            LOAD: begin
                w_x_ready_nxt = 1'b1;
                if (w_x_hs) begin
                    if (r_wcnt == W_LAST) begin
                        w_wcnt_nxt      = {AW{1'b0}};
                        w_oidx_nxt      = {AW{1'b0}};
                        w_k_nxt         = {FW{1'b0}};
                        w_x_ready_nxt   = 1'b0;
                        w_rd_addr_x_nxt = {AW{1'b0}};
                        w_rd_addr_f_nxt = {FW{1'b0}};
                        w_state_nxt     = ISSUE;
                    end else begin
                        w_wcnt_nxt = r_wcnt + AW'(1);
                    end
                end else begin
                    w_wcnt_nxt = r_wcnt;
                end
            end

            ISSUE: begin
                // read data for the address shown now arrives next cycle
                w_mac_en_nxt    = 1'b1;
                w_mac_first_nxt = (r_k == {FW{1'b0}});
                if (r_k == K_LAST) begin
                    w_k_nxt     = {FW{1'b0}};
                    w_state_nxt = DRAIN;
                end else begin
                    w_k_nxt         = r_k + FW'(1);
                    w_rd_addr_x_nxt = AW'(w_next_tap_sum);
                    w_rd_addr_f_nxt = r_k + FW'(1);
                end
            end

            DRAIN: begin
                w_y_valid_nxt = 1'b1;
                w_state_nxt   = OUT;
            end

            OUT: begin
                if (w_y_hs) begin
                    w_y_valid_nxt = 1'b0;
                    if (r_oidx == O_LAST) begin
                        w_frame_done_nxt = 1'b1;
                        w_x_ready_nxt    = 1'b1;
                        w_state_nxt      = LOAD;
                    end else begin
                        w_oidx_nxt      = r_oidx + AW'(1);
                        w_k_nxt         = {FW{1'b0}};
                        w_rd_addr_x_nxt = r_oidx + AW'(1);
                        w_rd_addr_f_nxt = {FW{1'b0}};
                        w_state_nxt     = ISSUE;
                    end
                end else begin
                    w_y_valid_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt   = LOAD;
                w_wcnt_nxt    = {AW{1'b0}};
                w_x_ready_nxt = 1'b0;
                w_y_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset aborts any frame in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= LOAD;
            r_wcnt       <= {AW{1'b0}};
            r_oidx       <= {AW{1'b0}};
            r_k          <= {FW{1'b0}};
            r_x_ready    <= 1'b0;
            r_y_valid    <= 1'b0;
            r_rd_addr_x  <= {AW{1'b0}};
            r_rd_addr_f  <= {FW{1'b0}};
            r_mac_en     <= 1'b0;
            r_mac_first  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_oidx       <= w_oidx_nxt;
            r_k          <= w_k_nxt;
            r_x_ready    <= w_x_ready_nxt;
            r_y_valid    <= w_y_valid_nxt;
            r_rd_addr_x  <= w_rd_addr_x_nxt;
            r_rd_addr_f  <= w_rd_addr_f_nxt;
            r_mac_en     <= w_mac_en_nxt;
            r_mac_first  <= w_mac_first_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign x_ready    = r_x_ready;
    assign y_valid    = r_y_valid;
    assign wr_en_x    = w_x_hs;
    assign wr_addr_x  = r_wcnt;
    assign rd_addr_x  = r_rd_addr_x;
    assign rd_addr_f  = r_rd_addr_f;
    assign mac_en     = r_mac_en;
    assign mac_first  = r_mac_first;
    assign frame_done = r_frame_done;

endmodule

// File: doc/conv_ctrl.md
Name: conv_ctrl

Overview:
- Sequencing controller for a 1-D convolution datapath: an N-entry x memory (1 write port, 1 read port, 1-cycle read latency), an M-entry filter ROM (1-cycle read latency), and a MAC accumulator.
- Accepts a frame of N input words through a valid/ready handshake and generates the memory write/read addresses.
- Issues MAC load/accumulate strobes for each of the N-M+1 outputs and runs the output valid/ready handshake.
- Contains no arithmetic on data words; it owns control only.

Parameters:
- N, 16, input vector length (words per frame); N >= 2.
- M, 4, filter length; 2 <= M <= N.
- AW, $clog2(N), x memory address width.
- FW, $clog2(M), filter ROM address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = in reset).
- x_valid  input  1  upstream word available.
- x_ready  output  1  controller accepts an input word this cycle.
- y_ready  input  1  downstream accepts y.
- y_valid  output  1  MAC accumulator holds a finished output.
- wr_en_x  output  1  write strobe to x memory.
- wr_addr_x  output  AW  x memory write address.
- rd_addr_x  output  AW  x memory read address.
- rd_addr_f  output  FW  filter ROM read address.
- mac_en  output  1  accumulator update enable (memory data valid this cycle).
- mac_first  output  1  with mac_en: accumulator loads the product instead of adding.
- frame_done  output  1  single-cycle pulse after the last output's handshake.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=LOAD; wcnt, k and oidx = 0.
  - x_ready=0, y_valid=0, wr_en_x=0, mac_en=0, mac_first=0, frame_done=0.
  - All addresses = 0.
  - The first cycle after reset release is LOAD with x_ready=1.
- States: LOAD, ISSUE, DRAIN, OUT.
- LOAD:
  - x_ready=1 (registered, asserted from state).
  - wr_en_x = x_valid & x_ready (combinational); wr_addr_x = wcnt.
  - On each handshake wcnt increments; no advance without a handshake.
  - Handshake with wcnt==N-1: wcnt←0, oidx←0, k←0, go to ISSUE. x_ready is 0 the next cycle.
- ISSUE:
  - rd_addr_x = oidx+k, rd_addr_f = k (registered outputs, valid in the cycle shown).
  - k increments each cycle; after k==M-1 is issued, k←0 and go to DRAIN. ISSUE lasts exactly M cycles.
- mac_en / mac_first:
  - mac_en = 1 in the cycle after each ISSUE address cycle, i.e. ISSUE cycles 2..M plus DRAIN.
  - mac_first = 1 only with the k=0 data.
- DRAIN: one cycle, last mac_en, then go to OUT.
- OUT:
  - y_valid=1, held with no change to any other output until y_ready=1.
  - On handshake: if oidx==N-M, pulse frame_done, go to LOAD with x_ready=1 next cycle. Otherwise oidx++ and go to ISSUE.
- Latency: y_valid rises M+1 cycles after ISSUE entry. Per-output period is M+2 cycles with y_ready held high.
- Output count per frame: N-M+1 (13 at defaults).
- Address arithmetic:
  - oidx+k never exceeds N-1 by construction; the sum is computed in AW+1 bits and truncated.
  - No wrap of oidx past N-M.
- Inputs are ignored outside their state: x_valid outside LOAD, y_ready outside OUT.
- No frame overlap: load and compute are strictly sequential.
- Reset mid-operation in any state aborts immediately to the reset values. Partial frame data is discarded; a new frame starts at wcnt=0.

Test Plan:
- Reset, x_valid held 1:
  - wr_en_x for 16 consecutive cycles with wr_addr_x 0..15.
  - x_ready=0 the cycle after the 16th accept; ISSUE starts that cycle.
- First output:
  - ISSUE cycles c0..c3 show rd_addr_x 0,1,2,3 and rd_addr_f 0,1,2,3.
  - mac_en on c1..c4, mac_first only on c1.
  - y_valid=1 at c5.
- y_ready held 0 for 10 cycles in OUT:
  - y_valid stays 1; mac_en=0 and addresses frozen.
  - Handshake on the 11th cycle; the next ISSUE shows rd_addr_x 1..4.
- Full frame with y_ready=1:
  - 13 y handshakes.
  - Last ISSUE has rd_addr_x 12..15.
  - frame_done pulses one cycle; x_ready=1 the next cycle.
- Random x_valid / y_ready (50%) over 625 frames:
  - wcnt advances only on handshakes.
  - Exactly 8125 y handshakes.
  - No wr_en_x outside LOAD.
- reset=0 asserted mid-ISSUE (oidx=5, k=2):
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, x_ready=1 and the next write goes to wr_addr_x=0.
